// File: rtl/tone_synth.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tone_synth: DDS square-wave tone generator, glitch-free frequency update |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tone_synth #(
  parameter int unsigned CLK_HZ = 48_000_000,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned MAX_HZ = 20_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] frequency,
  input  logic        new_SPI,
  output logic        tone_out,
  output logic [7:0]  phase,
  output logic        active,
  output logic        load_ack
);

  localparam int unsigned PROD_W = 39;
  localparam int unsigned K_W    = PROD_W - 16;
  localparam longint unsigned K_FULL =
    ((64'd1 << (ACC_W + 16)) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);
  localparam logic [K_W-1:0] K = K_W'(K_FULL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  logic              new_spi_d_q, new_spi_d_d;
  logic [15:0]       f_q, f_d;
  logic              s0_v_q, s0_v_d;
  logic              s1_v_q, s1_v_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              pend_v_q, pend_v_d;
  logic [ACC_W-1:0]  pending_inc_q, pending_inc_d;
  logic [ACC_W-1:0]  cur_inc_q, cur_inc_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              tone_q, tone_d;
  state_t            state_q, state_d;

  logic              strb;
  logic              pend_ok;
  logic              muted;
  logic [ACC_W:0]    sum;
  logic              wrap;
  logic              load_ack_w;

  always_comb begin
    strb        = new_SPI & ~new_spi_d_q;
    new_spi_d_d = new_SPI;
    muted       = (frequency == '0) || (32'(frequency) > MAX_HZ);

    f_d = f_q;
    if (strb) begin
      f_d = muted ? '0 : frequency;
    end
    s0_v_d = strb;

    // A fresh strobe kills every older request still in flight, so the latest one wins.
    s1_v_d = s0_v_q & ~strb;
    prod_d = prod_q;
    if (s0_v_q) begin
      prod_d = PROD_W'(f_q) * PROD_W'(K);
    end

    pend_v_d      = s1_v_q & ~strb;
    pending_inc_d = pending_inc_q;
    if (pend_v_d) begin
      pending_inc_d = ACC_W'(prod_q >> 16);
    end
    pend_ok = pend_v_q & ~strb;
  end

  always_comb begin
    sum        = {1'b0, acc_q} + {1'b0, cur_inc_q};
    wrap       = sum[ACC_W];
    state_d    = state_q;
    acc_d      = acc_q;
    cur_inc_d  = cur_inc_q;
    load_ack_w = 1'b0;

    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        if (pend_ok && (pending_inc_q != '0)) begin
          cur_inc_d  = pending_inc_q;
          load_ack_w = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = sum[ACC_W-1:0];
        if (pend_ok) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        // Swap increments only on a phase wrap so the current half-cycle is never cut short.
        acc_d = sum[ACC_W-1:0];
        if (wrap) begin
          cur_inc_d  = pending_inc_q;
          load_ack_w = 1'b1;
          if (pending_inc_q != '0) begin
            state_d = S_RUN;
          end else begin
            acc_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        acc_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    tone_d = (state_d != S_IDLE) & acc_d[ACC_W-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      new_spi_d_q   <= 1'b0;
      f_q           <= '0;
      s0_v_q        <= 1'b0;
      s1_v_q        <= 1'b0;
      prod_q        <= '0;
      pend_v_q      <= 1'b0;
      pending_inc_q <= '0;
      cur_inc_q     <= '0;
      acc_q         <= '0;
      tone_q        <= 1'b0;
      state_q       <= S_IDLE;
    end else begin
      new_spi_d_q   <= new_spi_d_d;
      f_q           <= f_d;
      s0_v_q        <= s0_v_d;
      s1_v_q        <= s1_v_d;
      prod_q        <= prod_d;
      pend_v_q      <= pend_v_d;
      pending_inc_q <= pending_inc_d;
      cur_inc_q     <= cur_inc_d;
      acc_q         <= acc_d;
      tone_q        <= tone_d;
      state_q       <= state_d;
    end
  end

  assign tone_out = tone_q;
  assign active   = (state_q != S_IDLE);
  assign phase    = (state_q == S_IDLE) ? 8'd0 : acc_q[ACC_W-1 -: 8];
  assign load_ack = load_ack_w;

endmodule
`default_nettype wire
